// File: rtl/alu_rs_sched.sv
// Reservation station feeding the integer ALU: captures CDB operands, issues one ready entry per cycle.
// Optional macro RS_AGE_PRIORITY_EN selects oldest-ready-first instead of lowest-index-first.
module alu_rs_sched #(
  parameter int unsigned RS_SIZE  = 16,
  parameter int unsigned RS_IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rollback,
  input  logic        issue_valid,
  input  logic [6:0]  issue_opcode,
  input  logic [2:0]  issue_funct3,
  input  logic        issue_funct7,
  input  logic        issue_rs1_rdy,
  input  logic        issue_rs2_rdy,
  input  logic [31:0] issue_rs1_val,
  input  logic [31:0] issue_rs2_val,
  input  logic [3:0]  issue_rs1_tag,
  input  logic [3:0]  issue_rs2_tag,
  input  logic [31:0] issue_imm,
  input  logic [31:0] issue_pc,
  input  logic [3:0]  issue_rob_pos,
  output logic        rs_full,
  input  logic        alu_cdb_valid,
  input  logic [3:0]  alu_cdb_rob_pos,
  input  logic [31:0] alu_cdb_val,
  input  logic        lsb_cdb_valid,
  input  logic [3:0]  lsb_cdb_rob_pos,
  input  logic [31:0] lsb_cdb_val,
  output logic        alu_en,
  output logic [6:0]  alu_opcode,
  output logic [2:0]  alu_funct3,
  output logic        alu_funct7,
  output logic [31:0] alu_val1,
  output logic [31:0] alu_val2,
  output logic [31:0] alu_imm,
  output logic [31:0] alu_pc,
  output logic [3:0]  alu_rob_pos
);

  logic [RS_SIZE-1:0] busy, rdy1, rdy2;
  logic [6:0]  e_opcode [RS_SIZE];
  logic [2:0]  e_funct3 [RS_SIZE];
  logic        e_funct7 [RS_SIZE];
  logic [31:0] e_val1   [RS_SIZE];
  logic [31:0] e_val2   [RS_SIZE];
  logic [3:0]  e_tag1   [RS_SIZE];
  logic [3:0]  e_tag2   [RS_SIZE];
  logic [31:0] e_imm    [RS_SIZE];
  logic [31:0] e_pc     [RS_SIZE];
  logic [3:0]  e_rob    [RS_SIZE];
`ifdef RS_AGE_PRIORITY_EN
  logic [3:0]  age      [RS_SIZE];
  logic [3:0]  best_age;
`endif

  logic                sel_found, free_found;
  logic [RS_IDX_W-1:0] sel_idx, free_idx;
  logic [RS_IDX_W:0]   busy_cnt;
  logic                cap_rdy1, cap_rdy2;
  logic [31:0]         cap_val1, cap_val2;

  always_comb begin
    sel_found  = 1'b0;
    sel_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    busy_cnt   = '0;
`ifdef RS_AGE_PRIORITY_EN
    best_age   = '0;
`endif
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      busy_cnt = busy_cnt + (RS_IDX_W+1)'(busy[i]);
`ifdef RS_AGE_PRIORITY_EN
      // strict '>' keeps the lowest index on equal ages
      if (busy[i] && rdy1[i] && rdy2[i] && (!sel_found || age[i] > best_age)) begin
        sel_found = 1'b1;
        sel_idx   = RS_IDX_W'(i);
        best_age  = age[i];
      end
`else
      if (busy[i] && rdy1[i] && rdy2[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = RS_IDX_W'(i);
      end
`endif
      if (!busy[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = RS_IDX_W'(i);
      end
    end
  end

  assign rs_full = (busy_cnt >= (RS_IDX_W+1)'(RS_SIZE - 1));

  always_comb begin
    cap_rdy1 = issue_rs1_rdy;
    cap_val1 = issue_rs1_val;
    cap_rdy2 = issue_rs2_rdy;
    cap_val2 = issue_rs2_val;
    if (!issue_rs1_rdy) begin
      if (alu_cdb_valid && alu_cdb_rob_pos == issue_rs1_tag) begin
        cap_rdy1 = 1'b1;
        cap_val1 = alu_cdb_val;
      end else if (lsb_cdb_valid && lsb_cdb_rob_pos == issue_rs1_tag) begin
        cap_rdy1 = 1'b1;
        cap_val1 = lsb_cdb_val;
      end
    end
    if (!issue_rs2_rdy) begin
      if (alu_cdb_valid && alu_cdb_rob_pos == issue_rs2_tag) begin
        cap_rdy2 = 1'b1;
        cap_val2 = alu_cdb_val;
      end else if (lsb_cdb_valid && lsb_cdb_rob_pos == issue_rs2_tag) begin
        cap_rdy2 = 1'b1;
        cap_val2 = lsb_cdb_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || rollback) begin
      busy        <= '0;
      rdy1        <= '0;
      rdy2        <= '0;
      alu_en      <= 1'b0;
      alu_opcode  <= '0;
      alu_funct3  <= '0;
      alu_funct7  <= 1'b0;
      alu_val1    <= '0;
      alu_val2    <= '0;
      alu_imm     <= '0;
      alu_pc      <= '0;
      alu_rob_pos <= '0;
`ifdef RS_AGE_PRIORITY_EN
      for (int unsigned i = 0; i < RS_SIZE; i++) age[i] <= '0;
`endif
    end else if (rdy) begin
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        if (busy[i] && !rdy1[i]) begin
          if (alu_cdb_valid && alu_cdb_rob_pos == e_tag1[i]) begin
            rdy1[i] <= 1'b1;  e_val1[i] <= alu_cdb_val;
          end else if (lsb_cdb_valid && lsb_cdb_rob_pos == e_tag1[i]) begin
            rdy1[i] <= 1'b1;  e_val1[i] <= lsb_cdb_val;
          end
        end
        if (busy[i] && !rdy2[i]) begin
          if (alu_cdb_valid && alu_cdb_rob_pos == e_tag2[i]) begin
            rdy2[i] <= 1'b1;  e_val2[i] <= alu_cdb_val;
          end else if (lsb_cdb_valid && lsb_cdb_rob_pos == e_tag2[i]) begin
            rdy2[i] <= 1'b1;  e_val2[i] <= lsb_cdb_val;
          end
        end
`ifdef RS_AGE_PRIORITY_EN
        if (age[i] != 4'hf) age[i] <= age[i] + 4'd1;
`endif
      end
      alu_en <= sel_found;
      if (sel_found) begin
        busy[sel_idx] <= 1'b0;
        alu_opcode    <= e_opcode[sel_idx];
        alu_funct3    <= e_funct3[sel_idx];
        alu_funct7    <= e_funct7[sel_idx];
        alu_val1      <= e_val1[sel_idx];
        alu_val2      <= e_val2[sel_idx];
        alu_imm       <= e_imm[sel_idx];
        alu_pc        <= e_pc[sel_idx];
        alu_rob_pos   <= e_rob[sel_idx];
      end
      // free_idx comes from registered busy, so it never aliases the entry issuing now
      if (issue_valid && free_found) begin
        busy[free_idx]     <= 1'b1;
        e_opcode[free_idx] <= issue_opcode;
        e_funct3[free_idx] <= issue_funct3;
        e_funct7[free_idx] <= issue_funct7;
        rdy1[free_idx]     <= cap_rdy1;
        e_val1[free_idx]   <= cap_val1;
        e_tag1[free_idx]   <= issue_rs1_tag;
        rdy2[free_idx]     <= cap_rdy2;
        e_val2[free_idx]   <= cap_val2;
        e_tag2[free_idx]   <= issue_rs2_tag;
        e_imm[free_idx]    <= issue_imm;
        e_pc[free_idx]     <= issue_pc;
        e_rob[free_idx]    <= issue_rob_pos;
`ifdef RS_AGE_PRIORITY_EN
        age[free_idx]      <= '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_alu_rs_sched.sv
// Bench for alu_rs_sched: directed scenarios plus random traffic against a behavioural entry-table model.
module tb_alu_rs_sched;
  localparam int N = 16;

  logic clk = 1'b0;
  logic rst, rdy, rollback, issue_valid;
  logic [6:0] issue_opcode;
  logic [2:0] issue_funct3;
  logic issue_funct7, issue_rs1_rdy, issue_rs2_rdy;
  logic [31:0] issue_rs1_val, issue_rs2_val, issue_imm, issue_pc;
  logic [3:0] issue_rs1_tag, issue_rs2_tag, issue_rob_pos;
  logic rs_full;
  logic alu_cdb_valid, lsb_cdb_valid;
  logic [3:0] alu_cdb_rob_pos, lsb_cdb_rob_pos;
  logic [31:0] alu_cdb_val, lsb_cdb_val;
  logic alu_en, alu_funct7;
  logic [6:0] alu_opcode;
  logic [2:0] alu_funct3;
  logic [31:0] alu_val1, alu_val2, alu_imm, alu_pc;
  logic [3:0] alu_rob_pos;

  always #5 clk = ~clk;

  alu_rs_sched #(.RS_SIZE(16), .RS_IDX_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .issue_valid(issue_valid), .issue_opcode(issue_opcode), .issue_funct3(issue_funct3),
    .issue_funct7(issue_funct7), .issue_rs1_rdy(issue_rs1_rdy), .issue_rs2_rdy(issue_rs2_rdy),
    .issue_rs1_val(issue_rs1_val), .issue_rs2_val(issue_rs2_val),
    .issue_rs1_tag(issue_rs1_tag), .issue_rs2_tag(issue_rs2_tag),
    .issue_imm(issue_imm), .issue_pc(issue_pc), .issue_rob_pos(issue_rob_pos),
    .rs_full(rs_full),
    .alu_cdb_valid(alu_cdb_valid), .alu_cdb_rob_pos(alu_cdb_rob_pos), .alu_cdb_val(alu_cdb_val),
    .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_rob_pos(lsb_cdb_rob_pos), .lsb_cdb_val(lsb_cdb_val),
    .alu_en(alu_en), .alu_opcode(alu_opcode), .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
    .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_imm(alu_imm), .alu_pc(alu_pc),
    .alu_rob_pos(alu_rob_pos)
  );

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: a table of waiting micro-ops, each stamped with the ready-cycle it arrived in
  bit          m_busy [N];
  bit          m_r1 [N], m_r2 [N];
  logic [6:0]  m_opc [N];
  logic [2:0]  m_f3 [N];
  logic        m_f7 [N];
  logic [31:0] m_v1 [N], m_v2 [N], m_imm [N], m_pc [N];
  logic [3:0]  m_t1 [N], m_t2 [N], m_rob [N];
  int          m_stamp [N];
  int          rdy_cnt = 0;
  bit          m_en;
  logic [6:0]  m_aopc;
  logic [2:0]  m_af3;
  logic        m_af7;
  logic [31:0] m_av1, m_av2, m_aimm, m_apc;
  logic [3:0]  m_arob;

  wire [144:0] dut_bus = {alu_en, alu_opcode, alu_funct3, alu_funct7, alu_val1, alu_val2,
                          alu_imm, alu_pc, alu_rob_pos, rs_full};

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  function automatic logic [144:0] model_bus();
    return {m_en, m_aopc, m_af3, m_af7, m_av1, m_av2, m_aimm, m_apc, m_arob, m_count() >= N - 1};
  endfunction

  function automatic bit cdb_hit(input logic [3:0] tag, output logic [31:0] v);
    v = '0;
    if (alu_cdb_valid && alu_cdb_rob_pos == tag) begin v = alu_cdb_val; return 1'b1; end
    if (lsb_cdb_valid && lsb_cdb_rob_pos == tag) begin v = lsb_cdb_val; return 1'b1; end
    return 1'b0;
  endfunction

  task automatic model_edge();
    int sel, free, best, a;
    logic [31:0] v;
    if (rst || rollback) begin
      for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
      m_en = 1'b0; m_aopc = '0; m_af3 = '0; m_af7 = 1'b0;
      m_av1 = '0; m_av2 = '0; m_aimm = '0; m_apc = '0; m_arob = '0;
      return;
    end
    if (!rdy) return;
    sel = -1; free = -1; best = -1;
    for (int i = 0; i < N; i++) begin
      a = rdy_cnt - m_stamp[i];
      if (a > 15) a = 15;
`ifdef RS_AGE_PRIORITY_EN
      if (m_busy[i] && m_r1[i] && m_r2[i] && a > best) begin sel = i; best = a; end
`else
      if (m_busy[i] && m_r1[i] && m_r2[i] && sel < 0) sel = i;
`endif
      if (!m_busy[i] && free < 0) free = i;
    end
    if (issue_valid) begin
      vectors++;
      if (free < 0) begin
        miscompares++;
        $display("FAIL dispatch_when_full: busy=%0d required<%0d", m_count(), N);
      end
    end
    for (int i = 0; i < N; i++) if (m_busy[i]) begin
      if (!m_r1[i] && cdb_hit(m_t1[i], v)) begin m_r1[i] = 1'b1; m_v1[i] = v; end
      if (!m_r2[i] && cdb_hit(m_t2[i], v)) begin m_r2[i] = 1'b1; m_v2[i] = v; end
    end
    m_en = (sel >= 0);
    if (sel >= 0) begin
      m_busy[sel] = 1'b0;
      m_aopc = m_opc[sel]; m_af3 = m_f3[sel]; m_af7 = m_f7[sel];
      m_av1 = m_v1[sel]; m_av2 = m_v2[sel]; m_aimm = m_imm[sel];
      m_apc = m_pc[sel]; m_arob = m_rob[sel];
    end
    rdy_cnt++;
    if (issue_valid && free >= 0) begin
      m_busy[free] = 1'b1;
      m_opc[free] = issue_opcode; m_f3[free] = issue_funct3; m_f7[free] = issue_funct7;
      m_t1[free] = issue_rs1_tag; m_t2[free] = issue_rs2_tag;
      m_r1[free] = issue_rs1_rdy; m_v1[free] = issue_rs1_val;
      m_r2[free] = issue_rs2_rdy; m_v2[free] = issue_rs2_val;
      if (!issue_rs1_rdy && cdb_hit(issue_rs1_tag, v)) begin m_r1[free] = 1'b1; m_v1[free] = v; end
      if (!issue_rs2_rdy && cdb_hit(issue_rs2_tag, v)) begin m_r2[free] = 1'b1; m_v2[free] = v; end
      m_imm[free] = issue_imm; m_pc[free] = issue_pc; m_rob[free] = issue_rob_pos;
      m_stamp[free] = rdy_cnt;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; rdy = 1'b1; rollback = 1'b0; issue_valid = 1'b0;
    alu_cdb_valid = 1'b0; lsb_cdb_valid = 1'b0;
  endtask

  task automatic set_issue(input logic [6:0] opc, input logic f7,
                           input logic r1, input logic [31:0] v1, input logic [3:0] t1,
                           input logic r2, input logic [31:0] v2, input logic [3:0] t2,
                           input logic [3:0] rob);
    issue_valid = 1'b1; issue_opcode = opc; issue_funct3 = 3'd0; issue_funct7 = f7;
    issue_rs1_rdy = r1; issue_rs1_val = v1; issue_rs1_tag = t1;
    issue_rs2_rdy = r2; issue_rs2_val = v2; issue_rs2_tag = t2;
    issue_imm = 32'h100 + 32'(rob); issue_pc = 32'h8000 + 32'(rob) * 4; issue_rob_pos = rob;
  endtask

  task automatic test_reset();
    idle();
    alu_cdb_rob_pos = '0; alu_cdb_val = '0; lsb_cdb_rob_pos = '0; lsb_cdb_val = '0;
    set_issue(7'h33, 1'b0, 1'b1, 32'd1, 4'd0, 1'b1, 32'd2, 4'd0, 4'd0);
    issue_valid = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    vectors++;
    if (dut_bus !== 145'd0) begin
      miscompares++;
      $display("FAIL reset_state: dut=%h required=0", dut_bus);
    end
  endtask

  task automatic test_add();
    set_issue(7'h33, 1'b0, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0, 4'd3);
    tick();
    idle();
    vectors++;
    if (alu_en !== 1'b0) begin miscompares++; $display("FAIL add_latency: alu_en=%b required=0", alu_en); end
    tick();
    vectors++;
    if ({alu_en, alu_val1, alu_val2, alu_rob_pos} !== {1'b1, 32'd5, 32'd7, 4'd3} || dut_bus !== model_bus()) begin
      miscompares++;
      $display("FAIL add_issue: dut=%h model=%h", dut_bus, model_bus());
    end
    tick();
    vectors++;
    if (alu_en !== 1'b0) begin miscompares++; $display("FAIL add_single: alu_en=%b required=0", alu_en); end
  endtask

  task automatic test_wakeup();
    set_issue(7'h33, 1'b1, 1'b0, 32'hdead, 4'd2, 1'b1, 32'd3, 4'd0, 4'd4);
    tick();
    idle();
    tick();
    alu_cdb_valid = 1'b1; alu_cdb_rob_pos = 4'd2; alu_cdb_val = 32'h10;
    tick();
    alu_cdb_valid = 1'b0;
    vectors++;
    if (alu_en !== 1'b0) begin miscompares++; $display("FAIL wakeup_early: alu_en=%b required=0", alu_en); end
    tick();
    vectors++;
    if ({alu_en, alu_val1, alu_funct7, alu_rob_pos} !== {1'b1, 32'h10, 1'b1, 4'd4} || dut_bus !== model_bus()) begin
      miscompares++;
      $display("FAIL wakeup_issue: dut=%h model=%h", dut_bus, model_bus());
    end
  endtask

  task automatic test_dispatch_capture();
    set_issue(7'h33, 1'b0, 1'b1, 32'd9, 4'd0, 1'b0, 32'h0, 4'd6, 4'd5);
    lsb_cdb_valid = 1'b1; lsb_cdb_rob_pos = 4'd6; lsb_cdb_val = 32'hABCD;
    tick();
    idle();
    tick();
    vectors++;
    if ({alu_en, alu_val2, alu_rob_pos} !== {1'b1, 32'hABCD, 4'd5} || dut_bus !== model_bus()) begin
      miscompares++;
      $display("FAIL dispatch_capture: dut=%h model=%h", dut_bus, model_bus());
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 15; i++) begin
      set_issue(7'h13, 1'b0, 1'b0, 32'h0, 4'd9, 1'b1, 32'(i), 4'd0, 4'(i));
      tick();
    end
    idle();
    vectors++;
    if (rs_full !== 1'b1) begin miscompares++; $display("FAIL full_flag: rs_full=%b required=1", rs_full); end
    alu_cdb_valid = 1'b1; alu_cdb_rob_pos = 4'd9; alu_cdb_val = 32'h99;
    tick();
    idle();
    for (int i = 0; i < 15; i++) begin
      tick();
      vectors++;
      if ({alu_en, alu_rob_pos, alu_val1, alu_val2} !== {1'b1, 4'(i), 32'h99, 32'(i)} ||
          dut_bus !== model_bus() || (i == 0 && rs_full !== 1'b0)) begin
        miscompares++;
        $display("FAIL full_drain_%0d: dut=%h model=%h", i, dut_bus, model_bus());
      end
    end
    tick();
    vectors++;
    if (alu_en !== 1'b0) begin miscompares++; $display("FAIL full_empty: alu_en=%b required=0", alu_en); end
  endtask

  task automatic test_rdy_hold();
    set_issue(7'h37, 1'b0, 1'b1, 32'd11, 4'd0, 1'b1, 32'd12, 4'd0, 4'd7);
    tick();
    set_issue(7'h17, 1'b0, 1'b1, 32'd13, 4'd0, 1'b1, 32'd14, 4'd0, 4'd8);
    tick();
    idle();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      issue_valid = 1'b1;
      tick();
      vectors++;
      if ({alu_en, alu_rob_pos} !== {1'b1, 4'd7} || dut_bus !== model_bus()) begin
        miscompares++;
        $display("FAIL rdy_hold: dut=%h model=%h", dut_bus, model_bus());
      end
    end
    idle();
    tick();
    vectors++;
    if ({alu_en, alu_rob_pos} !== {1'b1, 4'd8} || dut_bus !== model_bus()) begin
      miscompares++;
      $display("FAIL rdy_resume: dut=%h model=%h", dut_bus, model_bus());
    end
    tick();
  endtask

  task automatic test_rollback();
    for (int i = 0; i < 4; i++) begin
      set_issue(7'h33, 1'b0, 1'b0, 32'h0, 4'd11, 1'b1, 32'd1, 4'd0, 4'(i));
      tick();
    end
    idle();
    rollback = 1'b1; issue_valid = 1'b1;
    alu_cdb_valid = 1'b1; alu_cdb_rob_pos = 4'd11; alu_cdb_val = 32'h77;
    tick();
    idle();
    vectors++;
    if (dut_bus !== 145'd0) begin miscompares++; $display("FAIL rollback_clear: dut=%h required=0", dut_bus); end
    alu_cdb_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (alu_en !== 1'b0 || dut_bus !== model_bus()) begin
        miscompares++;
        $display("FAIL rollback_noissue: dut=%h model=%h", dut_bus, model_bus());
      end
    end
    idle();
  endtask

  task automatic test_age_order();
    logic [3:0] first, second;
`ifdef RS_AGE_PRIORITY_EN
    first = 4'd1; second = 4'd2;
`else
    first = 4'd2; second = 4'd1;
`endif
    set_issue(7'h33, 1'b0, 1'b0, 32'h0, 4'd12, 1'b1, 32'd0, 4'd0, 4'd0);
    tick();
    set_issue(7'h33, 1'b0, 1'b0, 32'h0, 4'd13, 1'b1, 32'hA, 4'd0, 4'd1);
    tick();
    idle();
    alu_cdb_valid = 1'b1; alu_cdb_rob_pos = 4'd12; alu_cdb_val = 32'h5;
    tick();
    idle();
    tick();
    set_issue(7'h33, 1'b0, 1'b0, 32'h0, 4'd13, 1'b1, 32'hB, 4'd0, 4'd2);
    tick();
    idle();
    tick();
    alu_cdb_valid = 1'b1; alu_cdb_rob_pos = 4'd13; alu_cdb_val = 32'h6;
    tick();
    idle();
    tick();
    vectors++;
    if ({alu_en, alu_rob_pos} !== {1'b1, first} || dut_bus !== model_bus()) begin
      miscompares++;
      $display("FAIL age_first: dut=%h model=%h", dut_bus, model_bus());
    end
    tick();
    vectors++;
    if ({alu_en, alu_rob_pos} !== {1'b1, second} || dut_bus !== model_bus()) begin
      miscompares++;
      $display("FAIL age_second: dut=%h model=%h", dut_bus, model_bus());
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      idle();
      rdy = ($urandom_range(7) != 0);
      rollback = ($urandom_range(79) == 0);
      if (m_count() < N - 1 && $urandom_range(1) == 1) begin
        set_issue(7'($urandom), 1'($urandom), 1'($urandom), $urandom, 4'($urandom_range(7)),
                  1'($urandom), $urandom, 4'($urandom_range(7)), 4'($urandom));
        issue_funct3 = 3'($urandom);
      end
      alu_cdb_valid = 1'($urandom); alu_cdb_rob_pos = 4'($urandom_range(7)); alu_cdb_val = $urandom;
      lsb_cdb_valid = 1'($urandom); lsb_cdb_rob_pos = 4'($urandom_range(7)); lsb_cdb_val = $urandom;
      tick();
      vectors++;
      if (dut_bus !== model_bus()) begin
        miscompares++;
        $display("FAIL random_cycle_%0d: dut=%h model=%h", c, dut_bus, model_bus());
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_add();
    test_wakeup();
    test_dispatch_capture();
    test_full();
    test_rdy_hold();
    test_rollback();
    test_age_order();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_rs_sched.md
# alu_rs_sched

Reservation-station scheduler feeding the integer ALU. It holds up to `RS_SIZE` dispatched arithmetic, branch, jump, LUI and AUIPC micro-ops, and captures missing operands from the two common-data-bus broadcasts (ALU and LSB). Each cycle it selects one operand-complete entry and drives the ALU's registered issue port. It sits between the dispatcher/ROB and the ALU, and is flushed by `rollback`.

## Interface
Parameters:
- `RS_SIZE`, 16: number of entries (power of two, 2..16).
- `RS_IDX_W`, 4: log2(`RS_SIZE`).

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous, active-high
- `rdy`  in  1  global ready; when low, all state and outputs hold
- `rollback`  in  1  misprediction flush
- `issue_valid`  in  1  dispatch one micro-op this cycle
- `issue_opcode` / `issue_funct3` / `issue_funct7`  in  7/3/1  decoded fields
- `issue_rs1_rdy`, `issue_rs2_rdy`  in  1 each  operand value already valid
- `issue_rs1_val`, `issue_rs2_val`  in  32 each  operand value, if ready
- `issue_rs1_tag`, `issue_rs2_tag`  in  4 each  producing ROB position, if not ready
- `issue_imm`, `issue_pc`  in  32 each
- `issue_rob_pos`  in  4  destination ROB position
- `rs_full`  out  1  busy count >= `RS_SIZE`-1
- `alu_cdb_valid`, `alu_cdb_rob_pos`, `alu_cdb_val`  in  1/4/32  ALU broadcast
- `lsb_cdb_valid`, `lsb_cdb_rob_pos`, `lsb_cdb_val`  in  1/4/32  LSB broadcast
- `alu_en`  out  1  issue strobe to ALU
- `alu_opcode`, `alu_funct3`, `alu_funct7`, `alu_val1`, `alu_val2`, `alu_imm`, `alu_pc`, `alu_rob_pos`  out  7/3/1/32/32/32/32/4  issued micro-op

## Operation
- Per-entry state: busy, opcode, funct3, funct7, rdy1, val1, tag1, rdy2, val2, tag2, imm, pc, rob_pos, and age (4-bit, only when the macro is defined).
- Dispatch: when `issue_valid` is high, write the lowest-index non-busy entry. Dispatch while all entries are busy is illegal; the bench asserts it never happens.
- Dispatch-time capture: for each operand that is not ready, if its tag matches a same-cycle valid CDB `rob_pos`, store the value with rdy=1. ALU CDB wins if both broadcasts match.
- Wakeup: every busy entry whose rdyN=0 and tagN equals a valid CDB `rob_pos` latches the value and sets rdyN=1.
- Select: candidates are entries with busy, rdy1 and rdy2 all set, evaluated on registered state only. An entry woken this cycle becomes eligible next cycle.
- Issue: on the same edge, the selected entry is copied to the `alu_*` outputs, `alu_en` is set to 1 and the entry's busy bit is cleared. With no candidate, `alu_en` is 0 and the other outputs hold their last values.
- A freed entry may be re-dispatched on the following edge, not the same edge.
- rs_full = popcount(busy) >= `RS_SIZE`-1. It is computed from registers, which absorbs the dispatcher's one-cycle response lag.

## Timing
- Reset (`rst`): all busy=0; `alu_en`=0; all `alu_*` buses=0; `rs_full`=0.
- `rollback` (priority below `rst`, above `rdy`): same clearing as reset on that edge. Dispatch and CDB inputs in that cycle are ignored.
- `rdy`=0: no dispatch, wakeup or issue. Outputs hold, including a high `alu_en`.
- Latencies:
  - Dispatch with both operands ready at edge N: earliest `alu_en` at edge N+1.
  - CDB broadcast at edge N waking the last operand: earliest issue at edge N+1.
- Throughput: one issue per cycle.
- Simultaneous dispatch and issue in one cycle is allowed; they use distinct entries.

## Configuration
- `RS_AGE_PRIORITY_EN`:
  - Defined: each entry's age resets to 0 on dispatch and increments, saturating at 15, on every `rdy` cycle. Select picks the candidate with the greatest age; ties go to the lowest index.
  - Undefined: no age storage; select is lowest-index candidate first.

## Test plan
- Reset, then dispatch ADD (rs1=5 ready, rs2=7 ready, rob_pos=3) -> next edge `alu_en`=1, val1=5, val2=7, rob_pos=3; the following edge `alu_en`=0.
- Dispatch SUB with rs1 tag=2 not ready; on a later cycle `alu_cdb` reports rob_pos=2, val=0x10 -> issue one edge after the broadcast with val1=0x10.
- Dispatch with rs2 tag=6 in the same cycle as `lsb_cdb` rob_pos=6, val=0xABCD -> captured; issue next edge with val2=0xABCD.
- Fill 15 entries all waiting on tag 9 -> `rs_full`=1. Broadcast tag 9 -> entries issue one per cycle, 15 consecutive `alu_en` pulses, and `rs_full` drops after the first.
- Fill 4 entries, then assert `rollback` -> next edge all busy=0 and `alu_en`=0. A broadcast in the rollback cycle causes no issue.
- With `RS_AGE_PRIORITY_EN`: dispatch A into entry 1, free entry 0, then dispatch B into entry 0; wake both in the same cycle -> A issues before B. Without the macro, B issues first.
